// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin APB master: arbitrates, then drives SETUP/ACCESS.
// Ports: PCLK/PRESETn, req_* in, req_grant/rsp_* out, APB master signals.
// Optional: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
module apb_req_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              req_valid,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]              req_write,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [2*STRB_WIDTH-1:0] req_strb,
  input  logic [5:0]              req_prot,
  output logic [1:0]              req_grant,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PSELx,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [STRB_WIDTH-1:0]   PSTRB,
  output logic [2:0]              PPROT,
  output logic                    PWAKEUP,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state_q, state_d;

  logic owner_q, owner_d;
  logic last_q, last_d;
  logic any, win, do_grant;

  logic [1:0]            grant_d, rspv_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  err_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic                  psel_d, penable_d, pwrite_d, pwake_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_d;
  logic [2:0]            pprot_d;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
`endif

  // last_q is the requester granted most recently; the other one wins a tie.
  assign any = |req_valid;
  assign win = req_valid[1] & (~req_valid[0] | ~last_q);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    grant_d   = '0;
    rspv_d    = '0;
    rdata_d   = rsp_rdata;
    err_d     = rsp_err;
    paddr_d   = PADDR;
    psel_d    = PSELx;
    penable_d = PENABLE;
    pwrite_d  = PWRITE;
    pwdata_d  = PWDATA;
    pstrb_d   = PSTRB;
    pprot_d   = PPROT;
    pwake_d   = any | (state_q != IDLE);
    do_grant  = 1'b0;
`ifdef APB_TIMEOUT_EN
    tcnt_d    = tcnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        do_grant = any;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          rspv_d    = owner_q ? 2'b10 : 2'b01;
          err_d     = PSLVERR;
          rdata_d   = PWRITE ? '0 : PRDATA;
          penable_d = 1'b0;
          // Chain straight into the next SETUP when work is waiting.
          if (any) begin
            do_grant = 1'b1;
          end else begin
            state_d = IDLE;
            psel_d  = 1'b0;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rspv_d    = owner_q ? 2'b10 : 2'b01;
          err_d     = 1'b1;
          rdata_d   = '0;
          penable_d = 1'b0;
          psel_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    if (do_grant) begin
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      grant_d   = win ? 2'b10 : 2'b01;
      owner_d   = win;
      last_d    = win;
      paddr_d   = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                      : req_addr[ADDR_WIDTH-1:0];
      pwrite_d  = req_write[win];
      pprot_d   = win ? req_prot[5:3] : req_prot[2:0];
      if (req_write[win]) begin
        pwdata_d = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                       : req_wdata[DATA_WIDTH-1:0];
        pstrb_d  = win ? req_strb[2*STRB_WIDTH-1:STRB_WIDTH]
                       : req_strb[STRB_WIDTH-1:0];
      end else begin
        pstrb_d  = '0;
      end
`ifdef APB_TIMEOUT_EN
      tcnt_d    = '0;
`endif
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      req_grant <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      PWAKEUP   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      req_grant <= grant_d;
      rsp_valid <= rspv_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
      PADDR     <= paddr_d;
      PSELx     <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PWDATA    <= pwdata_d;
      PSTRB     <= pstrb_d;
      PPROT     <= pprot_d;
      PWAKEUP   <= pwake_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) tcnt_q <= '0;
    else          tcnt_q <= tcnt_d;
  end
`endif

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with hand-computed expectations.
// Covers single transfers, wait states, round-robin, errors, reset abort.
module tb_apb_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          PCLK, PRESETn;
  logic [1:0]    req_valid, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_strb;
  logic [5:0]    req_prot;
  logic [1:0]    req_grant, rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic          PSELx, PENABLE, PWRITE, PWAKEUP;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [SW-1:0] PSTRB;
  logic [2:0]    PPROT;
  logic          PREADY, PSLVERR;

  int n_chk = 0;
  int n_pass = 0;

  apb_req_arbiter dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .req_strb(req_strb), .req_prot(req_prot),
    .req_grant(req_grant), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PWAKEUP(PWAKEUP), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic wr, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input logic [2:0] p);
    if (i == 0) begin
      req_addr[AW-1:0]  = a;
      req_wdata[DW-1:0] = d;
      req_strb[SW-1:0]  = s;
      req_prot[2:0]     = p;
      req_write[0]      = wr;
    end else begin
      req_addr[2*AW-1:AW]  = a;
      req_wdata[2*DW-1:DW] = d;
      req_strb[2*SW-1:SW]  = s;
      req_prot[5:3]        = p;
      req_write[1]         = wr;
    end
  endtask

  initial begin
    PRESETn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_strb = '0; req_prot = '0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    #12;
    check("rst_psel", PSELx, 0);
    check("rst_pen", PENABLE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_grant", req_grant, 0);
    check("rst_rspv", rsp_valid, 0);
    check("rst_wake", PWAKEUP, 0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    tick();

    // Req0 write, zero wait states
    set_req(0, 32'h10, 1'b1, 32'hA5A5_A5A5, 4'hF, 3'b010);
    req_valid = 2'b01;
    PREADY = 1'b1;
    tick();
    check("t1_grant", req_grant, 2'b01);
    check("t1_psel", PSELx, 1);
    check("t1_pen0", PENABLE, 0);
    check("t1_paddr", PADDR, 32'h10);
    check("t1_pwrite", PWRITE, 1);
    check("t1_pwdata", PWDATA, 32'hA5A5_A5A5);
    check("t1_pstrb", PSTRB, 4'hF);
    check("t1_pprot", PPROT, 3'b010);
    check("t1_wake", PWAKEUP, 1);
    req_valid = 2'b00;
    tick();
    check("t1_pen1", PENABLE, 1);
    check("t1_grant0", req_grant, 0);
    check("t1_psel_acc", PSELx, 1);
    tick();
    check("t1_rspv", rsp_valid, 2'b01);
    check("t1_err", rsp_err, 0);
    check("t1_rdata", rsp_rdata, 0);
    check("t1_psel_end", PSELx, 0);
    check("t1_pen_end", PENABLE, 0);
    tick();
    check("t1_rspv_pulse", rsp_valid, 0);
    check("t1_wake_off", PWAKEUP, 0);
    check("t1_paddr_hold", PADDR, 32'h10);

    // Req1 read with three wait states
    set_req(1, 32'h20, 1'b0, 32'h0, 4'hF, 3'b101);
    req_valid = 2'b10;
    PREADY = 1'b0;
    tick();
    check("t2_grant", req_grant, 2'b10);
    check("t2_paddr", PADDR, 32'h20);
    check("t2_pwrite", PWRITE, 0);
    check("t2_pstrb", PSTRB, 0);
    check("t2_pwdata_hold", PWDATA, 32'hA5A5_A5A5);
    check("t2_pprot", PPROT, 3'b101);
    req_valid = 2'b00;
    tick();
    check("t2_pen", PENABLE, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_wait_pen", PENABLE, 1);
      check("t2_wait_psel", PSELx, 1);
      check("t2_wait_paddr", PADDR, 32'h20);
      check("t2_wait_rspv", rsp_valid, 0);
    end
    PREADY = 1'b1;
    PRDATA = 32'h1234_5678;
    tick();
    check("t2_rspv", rsp_valid, 2'b10);
    check("t2_rdata", rsp_rdata, 32'h1234_5678);
    check("t2_err", rsp_err, 0);
    check("t2_psel_end", PSELx, 0);

    // Both held: grants alternate starting with req0
    set_req(0, 32'h30, 1'b1, 32'h0000_1111, 4'h3, 3'b000);
    set_req(1, 32'h40, 1'b0, 32'h0, 4'hF, 3'b001);
    PRDATA = 32'hCAFE_0000;
    req_valid = 2'b11;
    tick();
    check("t3_g0", req_grant, 2'b01);
    check("t3_a0", PADDR, 32'h30);
    check("t3_pen0", PENABLE, 0);
    tick();
    check("t3_acc0", PENABLE, 1);
    check("t3_psel0", PSELx, 1);
    tick();
    check("t3_g1", req_grant, 2'b10);
    check("t3_rv0", rsp_valid, 2'b01);
    check("t3_rd0", rsp_rdata, 0);
    check("t3_a1", PADDR, 32'h40);
    check("t3_psel1", PSELx, 1);
    check("t3_pen1", PENABLE, 0);
    tick();
    check("t3_acc1", PENABLE, 1);
    tick();
    check("t3_g2", req_grant, 2'b01);
    check("t3_rv1", rsp_valid, 2'b10);
    check("t3_rd1", rsp_rdata, 32'hCAFE_0000);
    check("t3_psel2", PSELx, 1);
    tick();
    check("t3_acc2", PENABLE, 1);
    tick();
    check("t3_g3", req_grant, 2'b10);
    check("t3_rv2", rsp_valid, 2'b01);
    req_valid = 2'b00;
    tick();
    check("t3_acc3", PENABLE, 1);
    tick();
    check("t3_rv3", rsp_valid, 2'b10);
    check("t3_psel_end", PSELx, 0);

    // Slave error on req0 read, then a clean req1 write
    set_req(0, 32'h50, 1'b0, 32'h0, 4'hF, 3'b000);
    PRDATA = 32'hDEAD_0001;
    PSLVERR = 1'b1;
    req_valid = 2'b01;
    tick();
    check("t4_grant", req_grant, 2'b01);
    req_valid = 2'b00;
    tick();
    tick();
    check("t4_rspv", rsp_valid, 2'b01);
    check("t4_err", rsp_err, 1);
    check("t4_rdata", rsp_rdata, 32'hDEAD_0001);
    PSLVERR = 1'b0;
    set_req(1, 32'h60, 1'b1, 32'h6666_0000, 4'hC, 3'b000);
    req_valid = 2'b10;
    tick();
    check("t4_grant1", req_grant, 2'b10);
    check("t4_pstrb1", PSTRB, 4'hC);
    req_valid = 2'b00;
    tick();
    tick();
    check("t4_rspv1", rsp_valid, 2'b10);
    check("t4_err1", rsp_err, 0);
    check("t4_rdata1", rsp_rdata, 0);

`ifdef APB_TIMEOUT_EN
    // Slave never ready: abort after 16 ACCESS cycles
    set_req(0, 32'h70, 1'b0, 32'h0, 4'hF, 3'b000);
    PREADY = 1'b0;
    PRDATA = 32'hFFFF_FFFF;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    for (int k = 0; k < 15; k++) begin
      tick();
      check("t5_wait_psel", PSELx, 1);
      check("t5_wait_rspv", rsp_valid, 0);
    end
    tick();
    check("t5_rspv", rsp_valid, 2'b01);
    check("t5_err", rsp_err, 1);
    check("t5_rdata", rsp_rdata, 0);
    check("t5_psel", PSELx, 0);
    check("t5_pen", PENABLE, 0);
`endif

    // Reset during ACCESS, then req0 wins the tie
    set_req(1, 32'h80, 1'b0, 32'h0, 4'hF, 3'b000);
    set_req(0, 32'h90, 1'b1, 32'h9999_9999, 4'hF, 3'b000);
    PREADY = 1'b0;
    req_valid = 2'b10;
    tick();
    check("t6_grant", req_grant, 2'b10);
    req_valid = 2'b00;
    tick();
    check("t6_acc", PENABLE, 1);
    req_valid = 2'b11;
    #2 PRESETn = 1'b0;
    #1;
    check("t6_rst_psel", PSELx, 0);
    check("t6_rst_pen", PENABLE, 0);
    check("t6_rst_paddr", PADDR, 0);
    check("t6_rst_rspv", rsp_valid, 0);
    check("t6_rst_wake", PWAKEUP, 0);
    tick();
    check("t6_hold_rspv", rsp_valid, 0);
    #3 PRESETn = 1'b1;
    tick();
    check("t6_grant0", req_grant, 2'b01);
    check("t6_paddr0", PADDR, 32'h90);
    check("t6_rspv_none", rsp_valid, 0);
    req_valid = 2'b00;
    PREADY = 1'b1;
    tick();
    tick();
    check("t6_rspv0", rsp_valid, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Two-requester APB master controller: arbitrates round-robin between two transfer requesters and sequences the shared APB bus through SETUP/ACCESS phases.
- Sits between internal request sources (e.g. DMA and CPU-side config port) and the APB interconnect.
- Drives PADDR/PSELx/PENABLE/PWRITE/PWDATA/PSTRB/PPROT/PWAKEUP; samples PREADY/PRDATA/PSLVERR.
- Returns per-requester completion pulses with read data and error status.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width (8/16/32)
STRB_WIDTH, DATA_WIDTH/8, byte strobe width
TIMEOUT_CYCLES, 16, max ACCESS wait cycles before abort (used only with APB_TIMEOUT_EN)

Ports:
PCLK  in  1  clock, rising edge
PRESETn  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request; held with fields until its grant
req_addr  in  2*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_write  in  2  1=write, 0=read
req_wdata  in  2*DATA_WIDTH  write data, sliced as req_addr
req_strb  in  2*STRB_WIDTH  write strobes, sliced as req_addr
req_prot  in  6  PPROT per requester, [i*3 +: 3]
req_grant  out  2  one-hot, one-cycle pulse: request accepted
rsp_valid  out  2  one-hot, one-cycle pulse: transfer complete
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  PSLVERR (or timeout) status, valid with rsp_valid
PADDR  out  ADDR_WIDTH  APB address
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  STRB_WIDTH  APB strobes
PPROT  out  3  APB protection
PWAKEUP  out  1  APB wakeup
PREADY  in  1  slave ready
PRDATA  in  DATA_WIDTH  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer favours requester 0; timeout counter 0. Reset mid-transfer aborts immediately with no rsp_valid.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE: if any req_valid, arbitrate at the clock edge → SETUP. Winner's fields are registered onto APB outputs with PSELx=1, PENABLE=0, and req_grant[winner]=1 for that single SETUP cycle.
- Arbitration: a single request wins. If both are valid, the requester not granted last wins. Pointer updates on every grant.
- SETUP → ACCESS unconditionally after 1 cycle: PENABLE=1, address/control/data unchanged.
- ACCESS: hold all APB outputs while PREADY=0. On the edge where PREADY=1 is sampled:
  - rsp_valid[owner]=1 next cycle.
  - rsp_err=PSLVERR.
  - rsp_rdata=PRDATA for reads, 0 for writes.
  - PENABLE→0.
- Completion with a req_valid pending: arbitrate at the same edge and go directly to SETUP (PSELx stays 1, no IDLE cycle). Otherwise go to IDLE with PSELx=0.
- Minimum transfer: 2 cycles (SETUP + 1 ACCESS). Back-to-back throughput: 1 transfer per 2 cycles.
- Reads: PSTRB driven 0, PWDATA holds previous value.
- PWAKEUP=1 (registered) whenever any req_valid=1 or state≠IDLE; else 0.
- After a transfer, PADDR/PWRITE/PWDATA/PPROT hold their last values.
- rsp_rdata/rsp_err hold until the next completion.
- Requester must deassert or change req_valid after seeing its grant. A still-high req_valid is treated as a new request.

Optional Feature:
APB_TIMEOUT_EN
- Defined: counter increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT_CYCLES, the transfer aborts:
  - PSELx/PENABLE→0, state→IDLE.
  - rsp_valid[owner]=1 with rsp_err=1, rsp_rdata=0.
  - Counter clears on entry to SETUP.
- Undefined: ACCESS waits indefinitely for PREADY; TIMEOUT_CYCLES unused; no counter logic.

Test Plan:
- Req0 write addr 0x10, data 0xA5A5_A5A5, strb 0xF, PREADY=1 → grant[0] in SETUP cycle, PENABLE next cycle, rsp_valid[0] 1 cycle after ACCESS, rsp_err=0; PSELx low after.
- Req1 read addr 0x20, PREADY low 3 ACCESS cycles then high with PRDATA=0x1234_5678 → APB outputs stable 4 ACCESS cycles, rsp_rdata=0x1234_5678, PSTRB=0.
- Both req_valid held continuously, PREADY=1 → grants alternate 0,1,0,1; PSELx stays high; PENABLE toggles 0/1 every cycle.
- PSLVERR=1 with PREADY on req0 read → rsp_valid[0]=1, rsp_err=1; next transfer unaffected.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY held 0 → abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSELx=0.
- PRESETn low during ACCESS → all outputs 0 asynchronously, no rsp_valid; after release, pending req0 granted first.
